keypad_hex_entry: RTL and testbench
===================================

KEYPAD_HEX_ENTRY -- requirements
Module: keypad_hex_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 10000, meaning clock cycles per row-scan slot (legal ≥ 4).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical scan frames required to accept a press or release (legal 1..15).
REQ-003 SHALL have port clock, input, 1, the system clock on which all logic is rising-edge.
REQ-004 SHALL have port sys_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port row_out, output, 4, keypad row drive, active-low, one-hot-low.
REQ-006 SHALL have port col_in, input, 4, keypad column sense, active-low, externally pulled up, asynchronous.
REQ-007 SHALL have port clear, input, 1, synchronous clear of the entered value.
REQ-008 SHALL have port value, output, 16, four entered hex digits, newest in [3:0].
REQ-009 SHALL have port key_code, output, 4, code of the last accepted key.
REQ-010 SHALL have port key_valid, output, 1, one-cycle pulse on key acceptance.
REQ-011 SHALL have port key_held, output, 1, high while an accepted key remains pressed.

Function
REQ-012 SHALL pass col_in through a 2-flop synchronizer before any use.
REQ-013 SHALL count slot_cnt 0..SCAN_DIV-1, then wrap to 0 and advance row index 0→1→2→3→0.
REQ-014 SHALL drive row_out so that only bit[row] is 0; row 0 → 4'b1110, row 3 → 4'b0111.
REQ-015 SHALL sample synchronized columns only when slot_cnt==SCAN_DIV-1, giving ≥2 cycles of row settling.
REQ-016 SHALL define a frame as the four slots for rows 0..3, evaluated at the row-3 sample.
REQ-017 SHALL classify a frame with exactly one asserted (row,col) as key code 4*row+col; any other count (zero, or two or more / ghosting) SHALL classify as "none".
REQ-018 SHALL implement FSM states IDLE, DB_PRESS, PRESSED and DB_RELEASE.
REQ-019 In IDLE, a frame with key k SHALL load cand=k, set frame count=1 and go to DB_PRESS, except when DEBOUNCE_FRAMES==1, where it SHALL accept immediately.
REQ-020 In DB_PRESS, a frame equal to cand SHALL increment the count; on reaching DEBOUNCE_FRAMES it SHALL accept and go to PRESSED.
REQ-021 In DB_PRESS, a different key SHALL restart with cand=new and count=1, and "none" SHALL return to IDLE.
REQ-022 On accept, the block SHALL set key_code=cand and pulse key_valid for exactly one clock, one cycle after the deciding sample edge, and SHALL set value={value[11:0],cand} with the oldest digit discarded.
REQ-023 In PRESSED, key_held SHALL be 1 and any non-"none" frame, including a different key, SHALL be ignored; a "none" frame SHALL go to DB_RELEASE with count=1.
REQ-024 In DB_RELEASE, "none" frames SHALL increment the count and at DEBOUNCE_FRAMES SHALL go to IDLE with key_held=0; any key frame SHALL return to PRESSED.
REQ-025 The block SHALL accept at most one key per press/release cycle, with no auto-repeat.
REQ-026 clear SHALL set value=0 on the next edge without affecting FSM, scan or key_code.
REQ-027 On clear coincident with an accept, clear SHALL win: value=0 with no shift, while key_valid still pulses and key_code still updates.

Reset
REQ-028 While sys_rst_n=0, the block SHALL immediately set row_out=4'b1110, value=0, key_code=0, key_valid=0 and key_held=0, and SHALL clear slot_cnt, row, synchronizer, count and cand to 0, with FSM=IDLE.
REQ-029 Reset asserted mid-debounce or mid-press SHALL abort with no key_valid pulse; after release the block SHALL start a fresh frame at row 0, slot 0.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-030 Reset then idle: row_out SHALL cycle 1110,1101,1011,0111 with 4 clocks each, and value SHALL stay 0000.
REQ-031 Press row1/col2 steady: exactly one key_valid pulse after frame 2, with key_code=6, value=0x0006 and key_held=1 until 2 clear frames.
REQ-032 Enter 1,2,3,4,5 (each press/release): value SHALL read 0x2345, and a 1-frame key glitch SHALL produce no pulse.
REQ-033 Two keys in different rows and columns held together: no key_valid; a key already PRESSED plus a second key added: no new pulse.
REQ-034 clear asserted on the key_valid-causing edge: key_valid=1, key_code updated, value=0x0000.
REQ-035 sys_rst_n low during DB_PRESS: no pulse, outputs at reset values; a key held through release SHALL be accepted 2 frames later.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: scans a 4x4 active-low matrix keypad, debounces whole scan
// frames and shifts each accepted key into a four-digit hex entry register.
// Ports: clock/sys_rst_n (async active-low) | row_out drive, col_in sense |
//        clear | value, key_code, key_valid (1-cycle pulse), key_held.
module keypad_hex_entry #(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clock,
  input  logic        sys_rst_n,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_TARGET = 4'(DEBOUNCE_FRAMES);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       row;
  logic [1:0]       hit_cnt;   // saturates at 2: anything >1 is "none"
  logic [3:0]       hit_code;
  logic [1:0]       state;
  logic [3:0]       cand;
  logic [3:0]       db_cnt;

  logic             sample;
  logic             frame_done;
  logic [2:0]       row_hits;
  logic [1:0]       row_col;
  logic [1:0]       base_hits;
  logic [3:0]       base_code;
  logic [2:0]       hit_sum;
  logic [1:0]       new_hits;
  logic [3:0]       new_code;
  logic             frame_key;

  logic [1:0]       next_state;
  logic [3:0]       next_cand;
  logic [3:0]       next_cnt;
  logic             accept;
  logic [3:0]       accept_code;

  // Only one row is pulled low; sampling at the last slot cycle leaves the
  // row at least two synchronizer cycles to settle.
  assign row_out    = ~(4'b0001 << row);
  assign sample     = (slot_cnt == SLOT_LAST);
  assign frame_done = sample && (row == 2'd3);
  assign key_held   = (state == ST_PRESSED) || (state == ST_DB_RELEASE);

  // Pressed-column count and position for the row currently driven.
  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_sync[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  // Row 0 starts a new frame, so the accumulator is ignored there.
  always_comb begin
    base_hits = (row == 2'd0) ? 2'd0 : hit_cnt;
    base_code = (row == 2'd0) ? 4'd0 : hit_code;
    hit_sum   = {1'b0, base_hits} + row_hits;
    new_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    new_code  = (row_hits != 3'd0) ? {row, row_col} : base_code;
    frame_key = (new_hits == 2'd1);
  end

  always_comb begin
    next_state  = state;
    next_cand   = cand;
    next_cnt    = db_cnt;
    accept      = 1'b0;
    accept_code = cand;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (frame_key) begin
            if (DEBOUNCE_FRAMES == 1) begin
              accept      = 1'b1;
              accept_code = new_code;
              next_cand   = new_code;
              next_state  = ST_PRESSED;
              next_cnt    = 4'd0;
            end else begin
              next_cand  = new_code;
              next_cnt   = 4'd1;
              next_state = ST_DB_PRESS;
            end
          end
        end
        ST_DB_PRESS: begin
          if (!frame_key) begin
            next_state = ST_IDLE;
            next_cnt   = 4'd0;
          end else if (new_code == cand) begin
            if (db_cnt + 4'd1 == DB_TARGET) begin
              accept      = 1'b1;
              accept_code = cand;
              next_state  = ST_PRESSED;
              next_cnt    = 4'd0;
            end else begin
              next_cnt = db_cnt + 4'd1;
            end
          end else begin
            next_cand = new_code;
            next_cnt  = 4'd1;
          end
        end
        ST_PRESSED: begin
          // Extra or different keys while held are ignored: no auto-repeat.
          if (!frame_key && (new_hits == 2'd0 || new_hits == 2'd2)) begin
            if (DEBOUNCE_FRAMES == 1) begin
              next_state = ST_IDLE;
              next_cnt   = 4'd0;
            end else begin
              next_state = ST_DB_RELEASE;
              next_cnt   = 4'd1;
            end
          end
        end
        default: begin // ST_DB_RELEASE
          if (frame_key) begin
            next_state = ST_PRESSED;
            next_cnt   = 4'd0;
          end else if (db_cnt + 4'd1 == DB_TARGET) begin
            next_state = ST_IDLE;
            next_cnt   = 4'd0;
          end else begin
            next_cnt = db_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_meta <= 4'd0;
      col_sync <= 4'd0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_cnt <= '0;
      row      <= 2'd0;
      hit_cnt  <= 2'd0;
      hit_code <= 4'd0;
    end else if (sample) begin
      slot_cnt <= '0;
      row      <= row + 2'd1;
      hit_cnt  <= new_hits;
      hit_code <= new_code;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cand      <= 4'd0;
      db_cnt    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      value     <= 16'd0;
    end else begin
      state     <= next_state;
      cand      <= next_cand;
      db_cnt    <= next_cnt;
      key_valid <= accept;
      if (accept) key_code <= accept_code;
      // clear beats a coincident accept; the key is still reported.
      if (clear)       value <= 16'd0;
      else if (accept) value <= {value[11:0], accept_code};
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
module tb_keypad_hex_entry;

  localparam int SD = 4;
  localparam int DF = 2;

  logic        clock = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic        clear;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clock = ~clock;

  keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clock(clock), .sys_rst_n(sys_rst_n), .row_out(row_out), .col_in(col_in),
    .clear(clear), .value(value), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held)
  );

  // Physical keypad: a pressed key shorts its column to a driven-low row.
  function automatic logic [3:0] cols_for(input logic [15:0] k, input logic [3:0] rows_n);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows_n[r])
        for (int q = 0; q < 4; q++)
          if (k[4*r+q]) c[q] = 1'b0;
    return c;
  endfunction

  always_comb col_in = cols_for(keys, row_out);

  // ---------------- reference model (edge-indexed, run-length debounce) ----
  int          m_n;
  logic [3:0]  m_p1, m_p2;       // column values seen one and two edges ago
  int          m_hits, m_code;
  int          m_run, m_prev, m_none;
  bit          m_hold, m_kv;
  logic [3:0]  m_kc;
  logic [15:0] m_value;

  task automatic model_reset();
    m_n = 0; m_p1 = 4'd0; m_p2 = 4'd0; m_hits = 0; m_code = 0;
    m_run = 0; m_prev = 0; m_none = 0; m_hold = 0; m_kv = 0;
    m_kc = 4'd0; m_value = 16'd0;
  endtask

  task automatic model_edge(input logic [3:0] col_now, input bit clr);
    bit acc;
    int r, key;
    acc = 0;
    if (m_n % SD == SD - 1) begin
      r = (m_n / SD) % 4;
      if (r == 0) m_hits = 0;
      for (int q = 0; q < 4; q++)
        if (!m_p2[q]) begin m_hits++; m_code = 4*r + q; end
      if (r == 3) begin
        key = (m_hits == 1) ? m_code : -1;
        if (!m_hold) begin
          if (key < 0) m_run = 0;
          else begin
            if (m_run > 0 && key == m_prev) m_run++;
            else m_run = 1;
            m_prev = key;
            if (m_run == DF) begin acc = 1; m_hold = 1; m_none = 0; end
          end
        end else begin
          if (key < 0) begin
            m_none++;
            if (m_none == DF) begin m_hold = 0; m_run = 0; end
          end else m_none = 0;
        end
      end
    end
    m_kv = acc;
    if (acc) m_kc = 4'(m_prev);
    if (clr) m_value = 16'd0;
    else if (acc) m_value = {m_value[11:0], 4'(m_prev)};
    m_p2 = m_p1;
    m_p1 = col_now;
    m_n++;
  endtask

  function automatic logic [3:0] model_rows();
    logic [3:0] t;
    t = 4'b0001 << ((m_n / SD) % 4);
    return ~t;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] cn;
    cn = cols_for(keys, model_rows());
    @(posedge clock);
    model_edge(cn, clear);
    @(negedge clock);
    check("row_out", row_out, model_rows());
    check("key_valid", key_valid, m_kv);
    check("key_code", key_code, m_kc);
    check("value", value, m_value);
    check("key_held", key_held, m_hold);
    if (key_valid) pulses++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_row_out", row_out, 4'hE);
    check("rst_value", value, 16'h0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    sys_rst_n = 1'b1;
  endtask

  task automatic align_frame();
    for (int i = 0; i < 64 && (m_n % (4*SD)) != 0; i++) step();
  endtask

  typedef struct {
    int          key;
    int          press_cyc;
    int          rel_cyc;
    int          exp_pulses;
    logic [15:0] exp_value;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1, 48, 48, 1, 16'h0001};
    tbl[1] = '{2, 48, 48, 1, 16'h0012};
    tbl[2] = '{3, 48, 48, 1, 16'h0123};
    tbl[3] = '{4, 48, 48, 1, 16'h1234};
    tbl[4] = '{5, 48, 48, 1, 16'h2345};
    tbl[5] = '{9, 16, 48, 0, 16'h2345};   // single-frame glitch

    keys = 16'h0; clear = 1'b0; sys_rst_n = 1'b0;
    do_reset();

    // Idle scanning: model checks the row rotation every cycle.
    run(32);
    check("idle_value", value, 16'h0000);

    // Single steady key at row 1, column 2.
    pulses = 0;
    keys = 16'h1 << 6;
    run(48);
    check("k6_pulses", pulses, 1);
    check("k6_code", key_code, 4'd6);
    check("k6_value", value, 16'h0006);
    check("k6_held", key_held, 1'b1);
    keys = 16'h0;
    run(48);
    check("k6_released", key_held, 1'b0);
    check("k6_no_repeat", pulses, 1);

    // Digit entry table.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulses = 0;
      keys = 16'h1 << tbl[i].key;
      run(tbl[i].press_cyc);
      keys = 16'h0;
      run(tbl[i].rel_cyc);
      check($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
      check($sformatf("tbl%0d_value", i), value, tbl[i].exp_value);
    end

    // Ghosting pair, then a second key added to an accepted one.
    do_reset();
    pulses = 0;
    keys = (16'h1 << 0) | (16'h1 << 5);
    run(64);
    check("ghost_pulses", pulses, 0);
    keys = 16'h0;
    run(32);
    keys = 16'h1 << 6;
    run(48);
    keys = keys | (16'h1 << 9);
    run(48);
    check("second_key_pulses", pulses, 1);
    check("second_key_code", key_code, 4'd6);
    keys = 16'h0;
    run(48);

    // clear on the accepting edge.
    align_frame();
    keys = 16'h1 << 3;
    run(31);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_acc_valid", key_valid, 1'b1);
    check("clr_acc_code", key_code, 4'd3);
    check("clr_acc_value", value, 16'h0000);
    keys = 16'h0;
    run(48);

    // Reset during press debounce; key stays down through reset.
    align_frame();
    keys = 16'h1 << 10;
    run(20);
    do_reset();
    pulses = 0;
    run(31);
    check("rst_abort_pulses", pulses, 0);
    step();
    check("rst_after_valid", key_valid, 1'b1);
    check("rst_after_code", key_code, 4'd10);
    keys = 16'h0;
    run(48);

    // Randomized key activity against the model.
    do_reset();
    for (int it = 0; it < 200; it++) begin
      int mode, dur;
      mode = int'($urandom_range(0, 9));
      if (mode <= 5) keys = 16'h1 << $urandom_range(0, 15);
      else if (mode == 6) keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else keys = 16'h0;
      dur = int'($urandom_range(1, 60));
      for (int c = 0; c < dur; c++) begin
        clear = ($urandom_range(0, 15) == 0);
        step();
      end
      clear = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
